// File: rtl/sipo_rx_ctrl_pkg.sv
// Shared types and defaults for the serial-in/parallel-out frame controller.
package sipo_rx_ctrl_pkg;

    // Controller states: waiting for a start, collecting bits, word held for the consumer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Word width used when the instantiating level does not override it.
    localparam int DW_DEFAULT = 4;

endpackage : sipo_rx_ctrl_pkg

// File: rtl/sipo_ml.sv
// Right-shifting serial-in/parallel-out register: new bits enter at the MSB,
// so after DW shifts the first bit received sits in bit 0.
module sipo_ml #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          inp,
    output logic [DW-1:0] out
);

    // Shift one bit in from the top on every enabled edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (enb) begin
            out <= {inp, out[DW-1:1]};
        end
    end

endmodule : sipo_ml

// File: rtl/sipo_rx_ctrl.sv
// Frame controller for a right-shifting SIPO register. Gates the shift enable
// for exactly DW qualified bits after a start strobe, then holds the word on a
// valid/ready handshake and flags restarts and overruns.
//
// Handshake: data_o is offered while vld_o=1 and must not change until the
// cycle in which rdy_i=1 is seen; that edge completes the transfer. vld_o and
// data_o depend only on registered state, never combinationally on rdy_i.
module sipo_rx_ctrl
    import sipo_rx_ctrl_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          sdi_i,
    input  logic          bit_vld_i,
    input  logic          rdy_i,
    input  logic          clr_ovr_i,
    output logic [DW-1:0] data_o,
    output logic          vld_o,
    output logic          busy_o,
    output logic          frm_err_o,
    output logic          ovr_o,
    output logic [1:0]    state_o
);

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic          shift_en;
    logic          frm_err_q;
    logic          ovr_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a start during SHIFT restarts in place, a start in
    // HOLD only takes effect when the held word is accepted the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = SHIFT;
            end
            SHIFT: begin
                if (!start_i && bit_vld_i && (cnt_q == CNT_LAST)) state_d = HOLD;
            end
            HOLD: begin
                if (rdy_i) state_d = start_i ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state; the start/restart cycle never samples a bit.
    always_comb begin
        shift_en = (state_q == SHIFT) && bit_vld_i && !start_i;
        vld_o    = (state_q == HOLD);
        busy_o   = (state_q != IDLE);
        state_o  = state_q;
    end

    // Bit counter: zero outside SHIFT so every entry into SHIFT starts from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q != SHIFT || start_i) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Frame-restart pulse, one cycle after the offending start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= (state_q == SHIFT) && start_i;
        end
    end

    // Sticky overrun: a start dropped while a word waits; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if ((state_q == HOLD) && start_i && !rdy_i) begin
            ovr_q <= 1'b1;
        end else if (clr_ovr_i) begin
            ovr_q <= 1'b0;
        end
    end

    assign frm_err_o = frm_err_q;
    assign ovr_o     = ovr_q;

    sipo_ml #(
        .DW(DW)
    ) u_sipo (
        .clk(clk),
        .rst(rst),
        .enb(shift_en),
        .inp(sdi_i),
        .out(data_o)
    );

endmodule : sipo_rx_ctrl

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl at DW=4.
module tb_sipo_rx_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic         sdi_i;
    logic         bit_vld_i;
    logic         rdy_i;
    logic         clr_ovr_i;
    logic [W-1:0] data_o;
    logic         vld_o;
    logic         busy_o;
    logic         frm_err_o;
    logic         ovr_o;
    logic [1:0]   state_o;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] exp_q[$];

    sipo_rx_ctrl #(
        .DW(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .sdi_i(sdi_i),
        .bit_vld_i(bit_vld_i),
        .rdy_i(rdy_i),
        .clr_ovr_i(clr_ovr_i),
        .data_o(data_o),
        .vld_o(vld_o),
        .busy_o(busy_o),
        .frm_err_o(frm_err_o),
        .ovr_o(ovr_o),
        .state_o(state_o)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Present one qualified bit, then optional idle gap cycles.
    task automatic shift_bit(input logic b, input int gap);
        bit_vld_i = 1'b1;
        sdi_i     = b;
        tick();
        bit_vld_i = 1'b0;
        sdi_i     = 1'b0;
        ticks(gap);
    endtask

    // Scoreboard: compare the word offered at a handshake with the oldest expected word.
    task automatic sb_take(input string tag);
        logic [W-1:0] exp_w;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_w = exp_q.pop_front();
            check({tag, "_vld"}, 32'(vld_o), 32'd1);
            check({tag, "_data"}, 32'(data_o), 32'(exp_w));
        end
    endtask

    initial begin
        rst       = 1'b0;
        start_i   = 1'b0;
        sdi_i     = 1'b0;
        bit_vld_i = 1'b0;
        rdy_i     = 1'b0;
        clr_ovr_i = 1'b0;
        ticks(2);
        rst = 1'b1;
        tick();

        // 1: reset in the middle of a frame after two bits
        pulse_start();
        shift_bit(1'b1, 0);
        shift_bit(1'b1, 0);
        check("t1_pre_busy", 32'(busy_o), 32'd1);
        check("t1_pre_data", 32'(data_o), 32'hC);
        #2;
        rst = 1'b0;
        #1;
        check("t1_rst_data", 32'(data_o), 32'h0);
        check("t1_rst_vld", 32'(vld_o), 32'd0);
        check("t1_rst_busy", 32'(busy_o), 32'd0);
        check("t1_rst_frm_err", 32'(frm_err_o), 32'd0);
        check("t1_rst_ovr", 32'(ovr_o), 32'd0);
        check("t1_rst_state", 32'(state_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Stray qualified bit while idle is ignored
        shift_bit(1'b1, 0);
        check("idle_bit_busy", 32'(busy_o), 32'd0);
        check("idle_bit_data", 32'(data_o), 32'h0);

        // 2: contiguous bits 1,0,1,1 -> 4'hD; the start cycle carries a bit that must be ignored
        rdy_i     = 1'b1;
        exp_q.push_back(4'hD);
        start_i   = 1'b1;
        bit_vld_i = 1'b1;
        sdi_i     = 1'b0;
        tick();
        start_i   = 1'b0;
        shift_bit(1'b1, 0);
        shift_bit(1'b0, 0);
        shift_bit(1'b1, 0);
        check("t2_vld_before_last", 32'(vld_o), 32'd0);
        shift_bit(1'b1, 0);
        check("t2_state_hold", 32'(state_o), 32'd2);
        sb_take("t2");
        tick();
        check("t2_vld_drop", 32'(vld_o), 32'd0);
        check("t2_busy_drop", 32'(busy_o), 32'd0);

        // 3: gapped bits 0,1,1,0 -> 4'h6, held through 5 not-ready cycles
        rdy_i = 1'b0;
        exp_q.push_back(4'h6);
        pulse_start();
        shift_bit(1'b0, 2);
        shift_bit(1'b1, 2);
        check("t3_gap_vld", 32'(vld_o), 32'd0);
        shift_bit(1'b1, 2);
        shift_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_vld", 32'(vld_o), 32'd1);
            check("t3_hold_data", 32'(data_o), 32'h6);
            tick();
        end
        rdy_i = 1'b1;
        sb_take("t3");
        tick();
        check("t3_vld_drop", 32'(vld_o), 32'd0);
        rdy_i = 1'b0;

        // 4: restart after two bits, new frame 0,0,1,0 -> 4'h4
        exp_q.push_back(4'h4);
        pulse_start();
        shift_bit(1'b1, 0);
        shift_bit(1'b1, 0);
        check("t4_frm_err_idle", 32'(frm_err_o), 32'd0);
        start_i   = 1'b1;
        bit_vld_i = 1'b1;
        sdi_i     = 1'b1;
        tick();
        start_i   = 1'b0;
        check("t4_frm_err_pulse", 32'(frm_err_o), 32'd1);
        check("t4_restart_state", 32'(state_o), 32'd1);
        shift_bit(1'b0, 0);
        check("t4_frm_err_end", 32'(frm_err_o), 32'd0);
        shift_bit(1'b0, 0);
        shift_bit(1'b1, 0);
        shift_bit(1'b0, 0);
        check("t4_vld", 32'(vld_o), 32'd1);
        check("t4_data", 32'(data_o), 32'h4);

        // 5: start while held and not ready -> overrun, word kept
        pulse_start();
        check("t5_ovr_set", 32'(ovr_o), 32'd1);
        check("t5_vld_kept", 32'(vld_o), 32'd1);
        check("t5_data_kept", 32'(data_o), 32'h4);
        check("t5_state_hold", 32'(state_o), 32'd2);
        clr_ovr_i = 1'b1;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        check("t5_set_beats_clr", 32'(ovr_o), 32'd1);
        tick();
        clr_ovr_i = 1'b0;
        check("t5_ovr_clr", 32'(ovr_o), 32'd0);
        check("t5_data_still", 32'(data_o), 32'h4);

        // 6: accept and start in the same cycle, next frame 0,0,0,1 -> 4'h8
        exp_q.push_back(4'h8);
        rdy_i = 1'b1;
        sb_take("t6a");
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t6_busy_b2b", 32'(busy_o), 32'd1);
        check("t6_state_shift", 32'(state_o), 32'd1);
        check("t6_vld_low", 32'(vld_o), 32'd0);
        shift_bit(1'b0, 0);
        check("t6_busy_mid", 32'(busy_o), 32'd1);
        shift_bit(1'b0, 0);
        shift_bit(1'b0, 0);
        shift_bit(1'b1, 0);
        sb_take("t6b");
        check("t6_ovr_clear", 32'(ovr_o), 32'd0);
        tick();
        check("t6_idle", 32'(state_o), 32'd0);
        check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_sipo_rx_ctrl
